// File: rtl/memory_stream_pkg.sv
// Shared types and constants for the memory stream reader.
package memory_stream_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    localparam int unsigned FifoDepth = 2;
    localparam int unsigned FifoCntW  = $clog2(FifoDepth + 1);

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry FIFO with a registered head word; absorbs the memory read latency so that
// the stream keeps flowing at full rate under backpressure.
module stream_skid_fifo
    import memory_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [FifoCntW-1:0] count,
    output logic                head_valid,
    output logic [WIDTH-1:0]    head_data
);

    logic [WIDTH-1:0] tail_q;
    logic             pop_ok;

    assign pop_ok     = pop && (count != '0);
    assign head_valid = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            head_data <= '0;
            tail_q    <= '0;
        end else begin
            unique case ({push, pop_ok})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_data <= push_data;
                        count     <= 2'd1;
                    end else if (count == 2'd1) begin
                        tail_q <= push_data;
                        count  <= 2'd2;
                    end
                end
                2'b01: begin
                    if (count == 2'd2) head_data <= tail_q;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Simultaneous capture and pop keeps the occupancy unchanged.
                    if (count == 2'd1) begin
                        head_data <= push_data;
                    end else begin
                        head_data <= tail_q;
                        tail_q    <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/memory_stream_reader.sv
// Reads a contiguous address range from a one-cycle-latency memory and re-emits it as a
// valid/ready stream with a last tag.
module memory_stream_reader
    import memory_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DEPTH-1:0] base_addr,
    input  logic [DEPTH:0]   length,
    output logic             busy,
    output logic             done,
    output logic [DEPTH-1:0] mem_read_addr,
    input  logic [WIDTH-1:0] mem_read_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    state_e              state_q;
    logic [DEPTH-1:0]    addr_q;
    logic [DEPTH-1:0]    last_addr_q;
    logic [DEPTH:0]      issue_cnt_q;
    logic [DEPTH:0]      len_q;
    logic [DEPTH:0]      pop_cnt_q;
    logic                inflight_q;
    logic                busy_q;
    logic                done_q;

    logic [FifoCntW-1:0] fifo_count;
    logic [WIDTH:0]      head;
    logic [DEPTH:0]      cap_idx;
    logic [2:0]          occupancy;
    logic                pop;
    logic                issue;
    logic                cap_last;

    assign pop       = out_valid && out_ready;
    assign occupancy = {{(3 - FifoCntW){1'b0}}, fifo_count} + {2'b00, inflight_q};
    // Words already popped plus words held give the index of the word being captured.
    assign cap_idx   = pop_cnt_q + {{(DEPTH + 1 - FifoCntW){1'b0}}, fifo_count};
    assign cap_last  = (cap_idx == len_q - 1'b1);
    assign issue     = (state_q == StRun) && (occupancy <= 3'd1 + {2'b00, pop});

    assign mem_read_addr = issue ? addr_q : last_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign out_data      = head[WIDTH-1:0];
    assign out_last      = head[WIDTH] && out_valid;

    stream_skid_fifo #(
        .WIDTH(WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data ({cap_last, mem_read_data}),
        .pop       (pop),
        .count     (fifo_count),
        .head_valid(out_valid),
        .head_data (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            last_addr_q <= '0;
            issue_cnt_q <= '0;
            len_q       <= '0;
            pop_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (pop) pop_cnt_q <= pop_cnt_q + 1'b1;
            if (issue) begin
                last_addr_q <= addr_q;
                addr_q      <= addr_q + 1'b1;
                issue_cnt_q <= issue_cnt_q - 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (length == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= StRun;
                            busy_q      <= 1'b1;
                            addr_q      <= base_addr;
                            len_q       <= length;
                            issue_cnt_q <= length;
                            pop_cnt_q   <= '0;
                        end
                    end
                end
                StRun: begin
                    if (issue && issue_cnt_q == (DEPTH + 1)'(1)) state_q <= StDrain;
                end
                StDrain: begin
                    if (pop && out_last) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stream_reader.sv
// Directed bench for memory_stream_reader with a behavioural one-cycle-latency memory.
module tb_memory_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic        busy;
    logic        done;
    logic [7:0]  mem_read_addr;
    logic [15:0] mem_read_data = 16'h0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;

    int checks = 0;
    int failures = 0;

    logic [15:0] got_data[$];
    logic        got_last[$];
    int first_valid, done_cyc, last_pop_cyc, done_count;
    bit stable_err, addr_err, busy_seen, busy_c1, busy_at_done, timed_out;

    memory_stream_reader #(
        .DEPTH(8),
        .WIDTH(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    // Memory word i holds i + 0x100.
    always @(posedge clk) mem_read_data <= 16'h100 + 16'(mem_read_addr);

    // Runs one transfer from cycle 0 (start high) and records what the stream delivers.
    task automatic run_xfer(input logic [7:0] base, input int len, input int mode,
                            input int stray_cyc, input int max_cycles);
        int cnt_m, inf_m, issued_m;
        bit pop_m, issue_m, hold;
        logic [15:0] hold_data;
        logic [7:0] prev_addr;
        got_data.delete();
        got_last.delete();
        first_valid = -1; done_cyc = -1; last_pop_cyc = -1; done_count = 0;
        stable_err = 0; addr_err = 0; busy_seen = 0; busy_c1 = 0; busy_at_done = 1;
        timed_out = 1;
        cnt_m = 0; inf_m = 0; issued_m = 0; hold = 0; hold_data = '0;
        prev_addr = mem_read_addr;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            start     = (c == 0) || (c == stray_cyc);
            base_addr = (c == 0) ? base : 8'h40;
            length    = (c == 0) ? 9'(len) : 9'd5;
            out_ready = (mode == 0) ? 1'b1 : ((c % 6) == 0 || (c % 6) == 3 || (c % 6) == 5);
            #1;
            if (out_valid && first_valid < 0) first_valid = c;
            if (hold && (!out_valid || out_data !== hold_data)) stable_err = 1;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                last_pop_cyc = c;
            end
            hold = out_valid && !out_ready;
            hold_data = out_data;
            if (busy) busy_seen = 1;
            if (c == 1) busy_c1 = busy;
            if (done) begin
                done_count++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    busy_at_done = busy;
                end
            end
            // Occupancy model: FIFO words plus the read in flight.
            pop_m   = (cnt_m > 0) && out_ready;
            issue_m = (c >= 1) && (issued_m < len) && (cnt_m + inf_m - int'(pop_m) <= 1);
            if (cnt_m == 2 && !pop_m && mem_read_addr !== prev_addr) addr_err = 1;
            if (issue_m && mem_read_addr !== 8'(int'(base) + issued_m)) addr_err = 1;
            cnt_m = cnt_m + inf_m - int'(pop_m);
            inf_m = int'(issue_m);
            issued_m += int'(issue_m);
            prev_addr = mem_read_addr;
            if (done_cyc >= 0 && c >= done_cyc + 3) begin
                timed_out = 0;
                break;
            end
        end
        start = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, out_valid, out_last});
        end
        checks++;
        if (out_data !== 16'h0) begin
            failures++;
            $display("FAIL reset_out_data: got %h expected 0000", out_data);
        end
        checks++;
        if (mem_read_addr !== 8'h0) begin
            failures++;
            $display("FAIL reset_mem_read_addr: got %h expected 00", mem_read_addr);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        run_xfer(8'd4, 5, 0, -1, 60);
        checks++;
        if (timed_out) begin failures++; $display("FAIL basic_timeout: got 1 expected 0"); end
        checks++;
        if (first_valid != 3) begin
            failures++; $display("FAIL basic_first_valid: got %0d expected 3", first_valid);
        end
        checks++;
        if (got_data.size() != 5) begin
            failures++; $display("FAIL basic_count: got %0d expected 5", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 5; i++) begin
            checks++;
            if (got_data[i] !== 16'h104 + 16'(i) || got_last[i] !== (i == 4)) begin
                failures++;
                $display("FAIL basic_word%0d: got %h/%b expected %h/%b", i, got_data[i],
                         got_last[i], 16'h104 + 16'(i), (i == 4));
            end
        end
        checks++;
        if (last_pop_cyc != 7 || done_cyc != 8) begin
            failures++;
            $display("FAIL basic_done_timing: got pop %0d done %0d expected 7 8",
                     last_pop_cyc, done_cyc);
        end
        checks++;
        if (done_count != 1 || busy_c1 !== 1'b1 || busy_at_done !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy_done: got dones %0d busy1 %b busy@done %b expected 1 1 0",
                     done_count, busy_c1, busy_at_done);
        end
        checks++;
        if (addr_err) begin failures++; $display("FAIL basic_addr: got err expected none"); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_w[4];
        exp_w[0] = 16'h1FE; exp_w[1] = 16'h1FF; exp_w[2] = 16'h100; exp_w[3] = 16'h101;
        run_xfer(8'd254, 4, 0, -1, 60);
        checks++;
        if (timed_out || got_data.size() != 4) begin
            failures++;
            $display("FAIL wrap_count: got %0d timeout %b expected 4 0", got_data.size(),
                     timed_out);
        end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++;
            if (got_data[i] !== exp_w[i] || got_last[i] !== (i == 3)) begin
                failures++;
                $display("FAIL wrap_word%0d: got %h/%b expected %h/%b", i, got_data[i],
                         got_last[i], exp_w[i], (i == 3));
            end
        end
    endtask

    task automatic test_backpressure();
        run_xfer(8'd0, 8, 1, -1, 120);
        checks++;
        if (timed_out || got_data.size() != 8 || done_count != 1) begin
            failures++;
            $display("FAIL bp_count: got %0d words %0d dones expected 8 1", got_data.size(),
                     done_count);
        end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            checks++;
            if (got_data[i] !== 16'h100 + 16'(i) || got_last[i] !== (i == 7)) begin
                failures++;
                $display("FAIL bp_word%0d: got %h/%b expected %h/%b", i, got_data[i],
                         got_last[i], 16'h100 + 16'(i), (i == 7));
            end
        end
        checks++;
        if (stable_err) begin failures++; $display("FAIL bp_stable: got unstable expected stable"); end
        checks++;
        if (addr_err) begin failures++; $display("FAIL bp_addr_hold: got advance expected hold"); end
    endtask

    task automatic test_len0();
        run_xfer(8'd9, 0, 0, -1, 20);
        checks++;
        if (timed_out || done_count != 1 || done_cyc != 1) begin
            failures++;
            $display("FAIL len0_done: got %0d dones at %0d expected 1 at 1", done_count, done_cyc);
        end
        checks++;
        if (busy_seen || first_valid != -1 || got_data.size() != 0) begin
            failures++;
            $display("FAIL len0_quiet: got busy %b valid at %0d expected 0 -1", busy_seen,
                     first_valid);
        end
    endtask

    task automatic test_len256();
        int bad;
        bad = 0;
        run_xfer(8'd0, 256, 0, -1, 400);
        checks++;
        if (timed_out || got_data.size() != 256 || done_count != 1) begin
            failures++;
            $display("FAIL len256_count: got %0d words %0d dones expected 256 1",
                     got_data.size(), done_count);
        end
        for (int i = 0; i < got_data.size() && i < 256; i++)
            if (got_data[i] !== 16'h100 + 16'(i) || got_last[i] !== (i == 255)) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL len256_words: got %0d bad words expected 0", bad);
        end
        checks++;
        if (last_pop_cyc != 258) begin
            failures++; $display("FAIL len256_rate: got last pop %0d expected 258", last_pop_cyc);
        end
    endtask

    task automatic test_start_while_busy();
        run_xfer(8'h10, 3, 0, 2, 60);
        checks++;
        if (timed_out || got_data.size() != 3 || done_count != 1) begin
            failures++;
            $display("FAIL busy_start_count: got %0d words %0d dones expected 3 1",
                     got_data.size(), done_count);
        end
        for (int i = 0; i < got_data.size() && i < 3; i++) begin
            checks++;
            if (got_data[i] !== 16'h110 + 16'(i) || got_last[i] !== (i == 2)) begin
                failures++;
                $display("FAIL busy_start_word%0d: got %h/%b expected %h/%b", i, got_data[i],
                         got_last[i], 16'h110 + 16'(i), (i == 2));
            end
        end
    endtask

    task automatic test_reset_abort();
        bit seen_done;
        seen_done = 0;
        @(negedge clk);
        start = 1; base_addr = 8'd0; length = 9'd10; out_ready = 1;
        repeat (4) begin @(negedge clk); start = 0; end
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL abort_pre_valid: got %b expected 1", out_valid);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0000 || out_data !== 16'h0 ||
            mem_read_addr !== 8'h0) begin
            failures++;
            $display("FAIL abort_async: got flags %b data %h addr %h expected 0000 0000 00",
                     {busy, done, out_valid, out_last}, out_data, mem_read_addr);
        end
        repeat (3) begin @(negedge clk); #1; if (done) seen_done = 1; end
        rst_n = 1;
        repeat (3) begin @(negedge clk); #1; if (done || busy) seen_done = 1; end
        checks++;
        if (seen_done) begin failures++; $display("FAIL abort_no_done: got done expected none"); end
        run_xfer(8'd0, 2, 0, -1, 40);
        checks++;
        if (timed_out || done_count != 1 || got_data.size() != 2) begin
            failures++;
            $display("FAIL abort_restart: got %0d words %0d dones expected 2 1",
                     got_data.size(), done_count);
        end else begin
            checks++;
            if (got_data[0] !== 16'h100 || got_data[1] !== 16'h101 || got_last[0] !== 1'b0 ||
                got_last[1] !== 1'b1) begin
                failures++;
                $display("FAIL abort_restart_data: got %h %h last %b%b expected 0100 0101 01",
                         got_data[0], got_data[1], got_last[0], got_last[1]);
            end
        end
    endtask

    initial begin
        rst_n = 0; start = 0; base_addr = '0; length = '0; out_ready = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_len0();
        test_len256();
        test_start_while_busy();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
